// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the 4-bit ALU and benches, plus the sequencer state encoding.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_ROR  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_NAND = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    function automatic logic is_div(input logic [3:0] op);
        return op == OP_DIV || op == OP_MOD;
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command handshake, result handshake and ALU hookup of the sequencer.
interface alu_cmd_sequencer_if #(parameter int WIDTH = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_load;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_b, cmd_load, alu_y, res_ready,
        output cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_b, cmd_load, alu_y, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with full/empty flags and occupancy count.
module alu_cmd_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= i_data;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_wr ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_rd ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers {load, op, b} commands, issues them against the accumulator
// to an external ALU and returns each accumulator result over a valid/ready handshake.
module alu_cmd_sequencer import alu_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int EW = WIDTH + 5;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_s;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [EW-1:0]    w_entry;
    logic [CW-1:0]    w_unused_count;
    logic             w_load;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_b;
    logic             w_div0;

    assign w_pop          = r_state == ST_IDLE && !w_empty;
    assign {w_load, w_op, w_b} = w_entry;
    assign w_div0         = is_div(w_op) && w_b == '0;
    assign bus.cmd_ready  = !w_full;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_s      = r_s;
    assign bus.res_valid  = r_state == ST_RESP;
    assign bus.res_data   = r_data;
    assign bus.res_err    = r_err;

    alu_cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.cmd_valid),
        .i_data  ({bus.cmd_load, bus.cmd_op, bus.cmd_b}),
        .i_pop   (w_pop),
        .o_data  (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_count)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pop) w_next = (w_load || w_div0) ? ST_RESP : ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (bus.res_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // loads and zero-divisor commands answer straight from IDLE without touching the ALU
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_pop) begin
            if (w_load) begin
                r_acc  <= w_b;
                r_data <= w_b;
                r_err  <= 1'b0;
            end else if (w_div0) begin
                r_data <= r_acc;
                r_err  <= 1'b1;
            end else begin
                r_a <= r_acc;
                r_b <= w_b;
                r_s <= w_op;
            end
        end else if (r_state == ST_EXEC) begin
            r_acc  <= bus.alu_y;
            r_data <= bus.alu_y;
            r_err  <= 1'b0;
        end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed table, multi-cycle corner sequences and a randomized
// run scored against a command-level accumulator model.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic       ld;
        logic [3:0] op;
        logic [3:0] b;
        logic [3:0] ed;
        logic       ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl [8];
    logic [3:0] m_acc;
    logic [4:0] q [$];

    alu_cmd_sequencer_if #(.WIDTH(4)) bus();

    alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] t;
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return 4'((a * b) % 16);
            OP_DIV:  return b == 0 ? 4'd0 : a / b;
            OP_MOD:  return b == 0 ? 4'd0 : a % b;
            OP_SHL:  return a << b[1:0];
            OP_SHR:  return a >> b[1:0];
            OP_ROL:  begin t = {a, a} << b[1:0]; return t[7:4]; end
            OP_ROR:  begin t = {a, a} >> b[1:0]; return t[3:0]; end
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_GT:   return {3'b0, a > b};
            default: return ~(a & b);
        endcase
    endfunction

    assign bus.alu_y = alu_f(bus.alu_s, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic ld, input logic [3:0] op, input logic [3:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", 32'(n < 50), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [3:0] ed, input logic ee);
        int n = 0;
        bus.res_ready = 1'b0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_valid"}, 32'(bus.res_valid), 1);
        chk({name, "_data"}, 32'(bus.res_data), 32'(ed));
        chk({name, "_err"}, 32'(bus.res_err), 32'(ee));
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    function automatic void model(input logic ld, input logic [3:0] op, input logic [3:0] b);
        if (ld) begin
            m_acc = b;
            q.push_back({1'b0, b});
        end else if ((op == OP_DIV || op == OP_MOD) && b == 0) begin
            q.push_back({1'b1, m_acc});
        end else begin
            m_acc = alu_f(op, m_acc, b);
            q.push_back({1'b0, m_acc});
        end
    endfunction

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.res_ready = 1'b0;
        tbl = '{
            '{1'b1, OP_ADD, 4'd5, 4'd5,  1'b0},
            '{1'b0, OP_ADD, 4'd3, 4'd8,  1'b0},
            '{1'b1, OP_ADD, 4'd5, 4'd5,  1'b0},
            '{1'b0, OP_SUB, 4'd7, 4'd14, 1'b0},
            '{1'b0, OP_MUL, 4'd3, 4'd10, 1'b0},
            '{1'b1, OP_ADD, 4'd9, 4'd9,  1'b0},
            '{1'b0, OP_DIV, 4'd0, 4'd9,  1'b1},
            '{1'b0, OP_MOD, 4'd4, 4'd1,  1'b0}
        };
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_data", 32'(bus.res_data), 0);
        chk("rst_res_err", 32'(bus.res_err), 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s}), 0);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].ld, tbl[i].op, tbl[i].b);
            recv($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ee);
            if (tbl[i].ee) chk("div0_alu_s", 32'(bus.alu_s), 32'(OP_MUL));
        end
        m_acc = 4'd1;

        // stall results: one command in flight plus DEPTH queued, then backpressure
        begin
            int acc_n = 0;
            logic [3:0] e;
            bus.cmd_valid = 1'b1;
            bus.cmd_load  = 1'b0;
            bus.cmd_op    = OP_ADD;
            for (int c = 0; c < 20; c++) begin
                bus.cmd_b = 4'(acc_n + 1);
                if (bus.cmd_ready) acc_n++;
                @(posedge clk); #1;
            end
            bus.cmd_valid = 1'b0;
            chk("full_accepts", 32'(acc_n), 5);
            chk("full_ready_low", 32'(bus.cmd_ready), 0);
            e = m_acc;
            for (int k = 1; k <= 5; k++) begin
                e = e + 4'(k);
                recv($sformatf("drain%0d", k), e, 1'b0);
            end
            acc_n = 0;
            for (int c = 0; c < 6; c++) begin
                if (bus.res_valid) acc_n++;
                @(posedge clk); #1;
            end
            chk("drain_no_dup", 32'(acc_n), 0);
        end

        // async reset in the middle of EXEC with a second command still queued
        send(1'b1, OP_ADD, 4'd3);
        recv("pre_load", 4'd3, 1'b0);
        send(1'b0, OP_ADD, 4'd4);
        send(1'b0, OP_ADD, 4'd1);
        chk("exec_alu_a", 32'(bus.alu_a), 3);
        chk("exec_alu_s", 32'(bus.alu_s), 32'(OP_ADD));
        rst_n = 1'b0;
        #1;
        chk("exec_rst_valid", 32'(bus.res_valid), 0);
        chk("exec_rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s}), 0);
        chk("exec_rst_ready", 32'(bus.cmd_ready), 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b1, OP_ADD, 4'd2);
        recv("post_rst_load", 4'd2, 1'b0);
        begin
            int n = 0;
            for (int c = 0; c < 6; c++) begin
                if (bus.res_valid) n++;
                @(posedge clk); #1;
            end
            chk("post_rst_fifo_empty", 32'(n), 0);
        end

        // async reset while a result is waiting in RESP
        send(1'b1, OP_ADD, 4'd7);
        @(posedge clk); #1;
        chk("resp_hold_valid", 32'(bus.res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("resp_rst_valid", 32'(bus.res_valid), 0);
        chk("resp_rst_data", 32'(bus.res_data), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back ADD 1 with res_ready high: one result every 3 cycles
        begin
            int pushed = 0, got = 0, last_c = 0;
            logic [3:0] prev = 4'd0;
            bus.res_ready = 1'b1;
            bus.cmd_load  = 1'b0;
            bus.cmd_op    = OP_ADD;
            bus.cmd_b     = 4'd1;
            for (int c = 0; c < 60; c++) begin
                bus.cmd_valid = pushed < 8;
                #1;
                if (bus.cmd_valid && bus.cmd_ready) pushed++;
                if (bus.res_valid) begin
                    chk("b2b_alu_a", 32'(bus.alu_a), 32'(prev));
                    chk("b2b_data", 32'(bus.res_data), 32'(prev + 4'd1));
                    if (got > 0) chk("b2b_interval", 32'(c - last_c), 3);
                    prev = bus.res_data;
                    last_c = c;
                    got++;
                end
                @(posedge clk); #1;
            end
            bus.cmd_valid = 1'b0;
            bus.res_ready = 1'b0;
            chk("b2b_count", 32'(got), 8);
            m_acc = 4'd8;
        end

        // randomized traffic against the command-level model
        begin
            logic ca, ra;
            logic [4:0] got_r, e;
            int n = 0;
            for (int c = 0; c < 800; c++) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_load  = $urandom_range(0, 3) == 0;
                bus.cmd_op    = 4'($urandom);
                bus.cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                bus.res_ready = $urandom_range(0, 2) != 0;
                #1;
                ca = bus.cmd_valid && bus.cmd_ready;
                ra = bus.res_valid && bus.res_ready;
                got_r = {bus.res_err, bus.res_data};
                @(posedge clk); #1;
                if (ra) begin
                    if (q.size() == 0) chk("rnd_extra_result", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("rnd_result", 32'(got_r), 32'(e));
                    end
                end
                if (ca) model(bus.cmd_load, bus.cmd_op, bus.cmd_b);
            end
            bus.cmd_valid = 1'b0;
            bus.res_ready = 1'b1;
            while (q.size() != 0 && n < 200) begin
                if (bus.res_valid) begin
                    e = q.pop_front();
                    chk("rnd_drain", 32'({bus.res_err, bus.res_data}), 32'(e));
                end
                @(posedge clk); #1;
                n++;
            end
            chk("rnd_left", 32'(q.size()), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
